// File: rtl/packer_2to8.sv
// rtl/packer_2to8.sv - packs consecutive 2-bit symbols MSB-first into 8-bit words behind a one-entry output register
module packer_2to8 #(
  parameter int SYM_W = 2,
  parameter int N_SYM = 4
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic [SYM_W-1:0]          data_in,
  input  logic                      valid_in,
  input  logic                      ready_in,
  output logic [SYM_W*N_SYM-1:0]    data_out,
  output logic                      valid_out,
  output logic                      overflow,
  output logic [$clog2(N_SYM)-1:0]  sym_count
);

  localparam int OUT_W = SYM_W * N_SYM;
  localparam int CNT_W = $clog2(N_SYM);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SYM - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state_q, state_d;
  logic   load, drop, complete;

  // Partial word keeps only the N_SYM-1 most recent symbols; the final one is
  // taken straight from data_in when the word completes.
  logic [OUT_W-SYM_W-1:0] shift_q;
  logic [OUT_W-1:0]       word_next;

  assign word_next = {shift_q, data_in};
  assign complete  = valid_in && (sym_count == LAST);
  assign valid_out = (state_q == FULL);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (complete) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (complete) begin
          if (ready_in) load = 1'b1;
          else          drop = 1'b1;
        end else if (ready_in) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= EMPTY;
      shift_q   <= '0;
      sym_count <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (valid_in) begin
        shift_q   <= word_next[OUT_W-SYM_W-1:0];
        sym_count <= (sym_count == LAST) ? '0 : sym_count + CNT_W'(1);
      end
      if (load) data_out <= word_next;
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_packer_2to8.sv
// tb/tb_packer_2to8.sv - directed self-checking bench for packer_2to8
module tb_packer_2to8;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic [1:0] data_in = 2'b00;
  logic       valid_in = 1'b0;
  logic       ready_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       overflow;
  logic [1:0] sym_count;

  int checks = 0;
  int failures = 0;

  packer_2to8 #(.SYM_W(2), .N_SYM(4)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .overflow  (overflow),
    .sym_count (sym_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive at the falling edge, sample 1 time unit after the following rising edge.
  task automatic step(input logic v, input logic [1:0] d, input logic r);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    ready_in = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_L  = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    data_in  = 2'b00;
    @(negedge clk);
    reset_L  = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_L  = 1'b0;
    valid_in = 1'b1;
    data_in  = 2'b11;
    ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sym_count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", sym_count); end
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++;
    if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    @(negedge clk);
    reset_L = 1'b1;
    data_in = 2'b10;
    @(posedge clk);
    #1;
    checks++;
    if (sym_count !== 2'd1) begin failures++; $display("FAIL reset_first_edge got=%0d exp=1", sym_count); end
  endtask

  task automatic test_basic();
    logic [1:0] syms [4];
    logic [1:0] cnt_exp [4];
    syms    = '{2'b11, 2'b10, 2'b01, 2'b00};
    cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, syms[i], 1'b0);
      checks++;
      if (sym_count !== cnt_exp[i]) begin failures++; $display("FAIL basic_count[%0d] got=%0d exp=%0d", i, sym_count, cnt_exp[i]); end
      checks++;
      if (valid_out !== (i == 3)) begin failures++; $display("FAIL basic_valid[%0d] got=%b exp=%b", i, valid_out, (i == 3)); end
    end
    checks++;
    if (data_out !== 8'hE4) begin failures++; $display("FAIL basic_data got=%h exp=e4", data_out); end
  endtask

  task automatic test_gapped();
    logic       vs [8];
    logic [1:0] ds [8];
    logic [1:0] cnt_exp [8];
    vs      = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ds      = '{2'b11, 2'b00, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00};
    cnt_exp = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(vs[i], ds[i], 1'b0);
      checks++;
      if (sym_count !== cnt_exp[i]) begin failures++; $display("FAIL gapped_count[%0d] got=%0d exp=%0d", i, sym_count, cnt_exp[i]); end
    end
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'hE4) begin
      failures++; $display("FAIL gapped_word got=%b/%h exp=1/e4", valid_out, data_out);
    end
  endtask

  task automatic test_streaming();
    logic [1:0] syms [8];
    syms = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, syms[i], 1'b1);
      if (i == 3) begin
        checks++;
        if (valid_out !== 1'b1 || data_out !== 8'h1B) begin
          failures++; $display("FAIL stream_word1 got=%b/%h exp=1/1b", valid_out, data_out);
        end
      end
      if (i == 4) begin
        checks++;
        if (valid_out !== 1'b0 || data_out !== 8'h1B) begin
          failures++; $display("FAIL stream_drain got=%b/%h exp=0/1b", valid_out, data_out);
        end
      end
    end
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'hE4 || overflow !== 1'b0) begin
      failures++; $display("FAIL stream_word2 got=%b/%h/%b exp=1/e4/0", valid_out, data_out, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] syms [8];
    syms = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, syms[i], (i == 7));
      if (i >= 3 && i < 7) begin
        checks++;
        if (valid_out !== 1'b1 || data_out !== 8'h1B) begin
          failures++; $display("FAIL b2b_hold[%0d] got=%b/%h exp=1/1b", i, valid_out, data_out);
        end
      end
    end
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'hE4 || overflow !== 1'b0) begin
      failures++; $display("FAIL b2b_swap got=%b/%h/%b exp=1/e4/0", valid_out, data_out, overflow);
    end
  endtask

  task automatic test_overflow();
    logic [1:0] syms [4];
    syms = '{2'b11, 2'b10, 2'b01, 2'b00};
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, syms[i], 1'b0);
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_before got=%b exp=0", overflow); end
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 1'b0);
    checks++;
    if (data_out !== 8'hE4 || valid_out !== 1'b1 || overflow !== 1'b1 || sym_count !== 2'd0) begin
      failures++; $display("FAIL ovf_drop got=%h/%b/%b/%0d exp=e4/1/1/0", data_out, valid_out, overflow, sym_count);
    end
    step(1'b0, 2'b00, 1'b1);
    checks++;
    if (valid_out !== 1'b0 || overflow !== 1'b1 || data_out !== 8'hE4) begin
      failures++; $display("FAIL ovf_drain got=%b/%b/%h exp=0/1/e4", valid_out, overflow, data_out);
    end
    #2;
    reset_L  = 1'b0;
    ready_in = 1'b0;
    #1;
    checks++;
    if (overflow !== 1'b0 || data_out !== 8'h00) begin
      failures++; $display("FAIL ovf_reset got=%b/%h exp=0/00", overflow, data_out);
    end
    #2;
    reset_L = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [1:0] syms [4];
    syms = '{2'b10, 2'b01, 2'b11, 2'b00};
    do_reset();
    step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    checks++;
    if (sym_count !== 2'd2) begin failures++; $display("FAIL async_pre got=%0d exp=2", sym_count); end
    #2;
    reset_L  = 1'b0;
    valid_in = 1'b0;
    #1;
    checks++;
    if (sym_count !== 2'd0 || valid_out !== 1'b0) begin
      failures++; $display("FAIL async_clear got=%0d/%b exp=0/0", sym_count, valid_out);
    end
    #2;
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, syms[i], 1'b0);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h9C || sym_count !== 2'd0) begin
      failures++; $display("FAIL async_repack got=%b/%h/%0d exp=1/9c/0", valid_out, data_out, sym_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_streaming();
    test_back_to_back();
    test_overflow();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
